// File: rtl/irq_ctrl_unit.sv
// Memory-mapped interrupt controller: captures edge/level device IRQs, holds
// pending/mask/mode state, drives masked HWInt lines and reports top source.
module irq_ctrl_unit #(
  parameter logic [31:0] base = 32'h00007F20,
  parameter int unsigned NSRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  input  logic [NSRC-1:0]  IrqIn,
  output logic [NSRC-1:0]  HWInt
);

  localparam int unsigned IDW = 3;

  logic [NSRC-1:0] mask, pend, mode, irq_q;
  logic            gie;

  logic            sel, wr_mask, wr_pend, wr_mode, wr_ctrl;
  logic [NSRC-1:0] mask_next, pend_next, mode_next, w1c, rise, pm;
  logic            gie_next;
  logic [IDW-1:0]  id;
  logic            valid;

  logic unused_ok;
  assign unused_ok = &{1'b0, Addr[1:0], WD[31:NSRC]};

  // Address decode and next-state of the programmable registers
  always_comb begin
    sel     = (Addr[31:4] == base[31:4]);
    wr_mask = WE && sel && (Addr[3:2] == 2'd0);
    wr_pend = WE && sel && (Addr[3:2] == 2'd1);
    wr_mode = WE && sel && (Addr[3:2] == 2'd2);
    wr_ctrl = WE && sel && (Addr[3:2] == 2'd3);

    mask_next = wr_mask ? WD[NSRC-1:0] : mask;
    mode_next = wr_mode ? WD[NSRC-1:0] : mode;
    gie_next  = wr_ctrl ? WD[0] : gie;
    w1c       = wr_pend ? WD[NSRC-1:0] : '0;
    rise      = IrqIn & ~irq_q;

    // Edge sources: a new rising edge beats a same-cycle W1C.
    // Level sources simply follow the input. New MODE applies immediately,
    // so a level->edge switch keeps the held PEND bit.
    pend_next = (mode_next & (rise | (pend & ~w1c))) | (~mode_next & IrqIn);
  end

  // Lowest-numbered enabled pending source wins
  always_comb begin
    pm    = pend & mask;
    id    = '0;
    valid = |pm;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pm[i]) id = IDW'(i);
    end
  end

  always_comb begin
    RD = '0;
    case (Addr[3:2])
      2'd0:    RD = 32'(mask);
      2'd1:    RD = 32'(pend);
      2'd2:    RD = 32'(mode);
      default: RD = {16'h0, valid, 4'h0, id, 7'h0, gie};
    endcase
  end

  // irq_q tracks IrqIn during reset so a held-high input is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      mask  <= '0;
      pend  <= '0;
      mode  <= '1;
      gie   <= 1'b0;
      irq_q <= IrqIn;
      HWInt <= '0;
    end else begin
      mask  <= mask_next;
      pend  <= pend_next;
      mode  <= mode_next;
      gie   <= gie_next;
      irq_q <= IrqIn;
      HWInt <= pend_next & mask_next & {NSRC{gie_next}};
    end
  end

endmodule

// File: tb/tb_irq_ctrl_unit.sv
// Bench for irq_ctrl_unit: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural reference model.
module tb_irq_ctrl_unit;

  localparam logic [31:0] B = 32'h00007F20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr, WD, RD;
  logic        WE;
  logic [5:0]  IrqIn, HWInt;

  always #5 clk = ~clk;

  irq_ctrl_unit dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .WD(WD),
    .RD(RD), .IrqIn(IrqIn), .HWInt(HWInt)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit [5:0] m_mask, m_pend, m_mode, m_prev, m_hw;
  bit       m_gie;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    bit [5:0] en;
    r = 0;
    case (a[3:2])
      2'd0: r = {26'd0, m_mask};
      2'd1: r = {26'd0, m_pend};
      2'd2: r = {26'd0, m_mode};
      default: begin
        en = m_pend & m_mask;
        r[0] = m_gie;
        for (int i = 0; i < 6; i++) begin
          if (en[i]) begin
            r[15] = 1'b1;
            r[10:8] = 3'(i);
            break;
          end
        end
      end
    endcase
    return r;
  endfunction

  task automatic m_clock(input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [5:0] irq);
    bit hit;
    bit [5:0] nm, nmode, np;
    bit ng;
    if (r) begin
      m_mask = 0; m_pend = 0; m_mode = 6'h3F; m_gie = 0; m_prev = irq; m_hw = 0;
      return;
    end
    hit = we && (a >= B) && (a <= B + 32'hF);
    nm = m_mask; nmode = m_mode; ng = m_gie; np = m_pend;
    if (hit && a[3:2] == 2'd0) nm = wd[5:0];
    if (hit && a[3:2] == 2'd2) nmode = wd[5:0];
    if (hit && a[3:2] == 2'd3) ng = wd[0];
    for (int i = 0; i < 6; i++) begin
      if (nmode[i]) begin
        if (irq[i] && !m_prev[i]) np[i] = 1'b1;
        else if (hit && a[3:2] == 2'd1 && wd[i]) np[i] = 1'b0;
      end else begin
        np[i] = irq[i];
      end
    end
    m_mask = nm; m_mode = nmode; m_gie = ng; m_pend = np; m_prev = irq;
    m_hw = ng ? (np & nm) : 6'h00;
  endtask

  // One clock with model tracking; RD checked before the edge, HWInt after
  task automatic step(input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [5:0] irq, input bit chk_rd);
    reset = r; WE = we; Addr = a; WD = wd; IrqIn = irq;
    #1;
    if (chk_rd) chk("rd_model", RD, m_read(a));
    @(posedge clk);
    m_clock(r, we, a, wd, irq);
    #1;
    chk("hwint_model", {26'd0, HWInt}, {26'd0, m_hw});
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    WE = 1'b0; Addr = a;
    #1;
    chk(name, RD, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [5:0]  irq;
    logic [5:0]  exp_hw;
    logic [31:0] rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [19];

  initial begin
    logic [5:0] irq;
    logic [31:0] a, wd;
    int pick;

    reset = 1'b1; WE = 1'b0; Addr = B; WD = 0; IrqIn = 0;

    //            we    addr      wd       irq    hw     rd_addr  rd
    vt[0]  = '{1'b1, B,       32'h01, 6'h00, 6'h00, B,       32'h01};
    vt[1]  = '{1'b1, B+12,    32'h01, 6'h00, 6'h00, B+12,    32'h01};
    vt[2]  = '{1'b0, B,       32'h00, 6'h01, 6'h01, B+4,     32'h01};
    vt[3]  = '{1'b0, B,       32'h00, 6'h00, 6'h01, B+12,    32'h8001};
    vt[4]  = '{1'b1, B+4,     32'h01, 6'h00, 6'h00, B+4,     32'h00};
    vt[5]  = '{1'b1, B,       32'h00, 6'h00, 6'h00, B,       32'h00};
    vt[6]  = '{1'b0, B,       32'h00, 6'h04, 6'h00, B+4,     32'h04};
    vt[7]  = '{1'b1, B,       32'h04, 6'h00, 6'h04, B+12,    32'h8201};
    vt[8]  = '{1'b1, B+4,     32'h04, 6'h00, 6'h00, B+4,     32'h00};
    vt[9]  = '{1'b1, B,       32'h3F, 6'h00, 6'h00, B,       32'h3F};
    vt[10] = '{1'b0, B,       32'h00, 6'h12, 6'h12, B+12,    32'h8101};
    vt[11] = '{1'b1, B+4,     32'h02, 6'h12, 6'h10, B+12,    32'h8401};
    vt[12] = '{1'b1, B+4,     32'h10, 6'h00, 6'h00, B+12,    32'h0001};
    vt[13] = '{1'b1, B+4,     32'h08, 6'h08, 6'h08, B+4,     32'h08};
    vt[14] = '{1'b1, B+4,     32'h08, 6'h08, 6'h00, B+4,     32'h00};
    vt[15] = '{1'b1, B+8,     32'h00, 6'h20, 6'h20, B+8,     32'h00};
    vt[16] = '{1'b1, B+4,     32'h20, 6'h20, 6'h20, B+4,     32'h20};
    vt[17] = '{1'b0, B,       32'h00, 6'h00, 6'h00, B+4,     32'h00};
    vt[18] = '{1'b1, B+8,     32'h3F, 6'h00, 6'h00, B+8,     32'h3F};

    // reset state
    step(1'b1, 1'b0, B, 0, 6'h00, 1'b0);
    step(1'b1, 1'b0, B, 0, 6'h00, 1'b0);
    reset = 1'b0;
    peek("rst_mask", B,      32'h0);
    peek("rst_pend", B + 4,  32'h0);
    peek("rst_mode", B + 8,  32'h3F);
    peek("rst_ctrl", B + 12, 32'h0);

    foreach (vt[k]) begin
      reset = 1'b0; WE = vt[k].we; Addr = vt[k].addr; WD = vt[k].wd; IrqIn = vt[k].irq;
      @(posedge clk);
      m_clock(1'b0, vt[k].we, vt[k].addr, vt[k].wd, vt[k].irq);
      #1;
      chk($sformatf("vec%0d_hwint", k), {26'd0, HWInt}, {26'd0, vt[k].exp_hw});
      peek($sformatf("vec%0d_rd", k), vt[k].rd_addr, vt[k].exp_rd);
    end

    // IrqIn held high across reset release must not create edges
    step(1'b1, 1'b0, B, 0, 6'h3F, 1'b0);
    step(1'b1, 1'b0, B, 0, 6'h3F, 1'b0);
    step(1'b0, 1'b0, B + 4, 0, 6'h3F, 1'b1);
    step(1'b0, 1'b0, B + 4, 0, 6'h3F, 1'b1);
    peek("held_pend", B + 4, 32'h0);
    // out-of-range writes ignored
    step(1'b0, 1'b1, B + 32'h10, 32'h3F, 6'h3F, 1'b0);
    step(1'b0, 1'b1, B - 32'h4,  32'h01, 6'h3F, 1'b0);
    step(1'b0, 1'b1, B + 32'h18, 32'h00, 6'h3F, 1'b0);
    peek("oor_mask", B,      32'h0);
    peek("oor_ctrl", B + 12, 32'h0);
    peek("oor_mode", B + 8,  32'h3F);

    // reset mid-operation clears active interrupts
    step(1'b0, 1'b1, B,      32'h3F, 6'h00, 1'b1);
    step(1'b0, 1'b1, B + 12, 32'h01, 6'h00, 1'b1);
    step(1'b0, 1'b0, B + 12, 0,      6'h2A, 1'b1);
    chk("pre_rst_hw", {26'd0, HWInt}, 32'h2A);
    step(1'b1, 1'b0, B, 0, 6'h2A, 1'b0);
    chk("mid_rst_hw", {26'd0, HWInt}, 32'h0);
    reset = 1'b0;
    peek("mid_rst_pend", B + 4,  32'h0);
    peek("mid_rst_ctrl", B + 12, 32'h0);

    // randomized traffic against the model
    step(1'b1, 1'b0, B, 0, 6'h00, 1'b0);
    irq = 6'h00;
    for (int n = 0; n < 3000; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 8) a = B + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      else if (pick == 8) a = B + 32'h10 + 32'($urandom_range(0, 15));
      else a = $urandom;
      wd = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h3F);
      irq = irq ^ (6'($urandom) & 6'($urandom));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, a, wd, irq, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
